// File: rtl/music_track_player.sv
// music_track_player: plays a selected track from a fixed melody table as timed notes, each followed by a rest; define TRACK_LOOP_EN to repeat the track continuously
module music_track_player #(
  parameter int CLKS_PER_BEAT   = 10,
  parameter int GAP_CLKS        = 2,
  parameter int NOTES_PER_TRACK = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] select,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] pitch,
  output logic       playing,
  output logic [1:0] track,
  output logic [2:0] note_idx,
  output logic       done
);
  localparam int CW = $clog2(3 * CLKS_PER_BEAT + GAP_CLKS + 1);
  localparam logic [2:0] LAST = 3'(NOTES_PER_TRACK - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CLKS - 1);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  function automatic logic [3:0] tone(input logic [1:0] t, input logic [2:0] i);
    logic [4:0] s;
    s = {3'b000, t} * 5'd3 + {2'b00, i};
    return 4'(s >= 5'd15 ? s - 5'd15 : s) + 4'd1;
  endfunction
  function automatic logic [CW-1:0] note_last(input logic [2:0] i);
    return CW'((int'(i) % 3 + 1) * CLKS_PER_BEAT - 1);
  endfunction
  // sequencer: stop beats start, start restarts from note 0, otherwise step through notes and rests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pitch    <= '0;
      playing  <= 1'b0;
      track    <= '0;
      note_idx <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        cnt      <= '0;
        pitch    <= '0;
        playing  <= 1'b0;
        note_idx <= '0;
      end else if (start) begin
        state    <= PLAY;
        cnt      <= '0;
        pitch    <= tone(select, 3'd0);
        playing  <= 1'b1;
        track    <= select;
        note_idx <= '0;
      end else begin
        case (state)
          PLAY: begin
            if (cnt == note_last(note_idx)) begin
              state <= GAP;
              cnt   <= '0;
              pitch <= '0;
            end else cnt <= cnt + 1'b1;
          end
          GAP: begin
            if (cnt != GAP_LAST) cnt <= cnt + 1'b1;
            else begin
              cnt <= '0;
              if (note_idx != LAST) begin
                state    <= PLAY;
                note_idx <= note_idx + 3'd1;
                pitch    <= tone(track, note_idx + 3'd1);
              end else begin
                done     <= 1'b1;
                note_idx <= '0;
`ifdef TRACK_LOOP_EN
                state    <= PLAY;
                pitch    <= tone(track, 3'd0);
`else
                state    <= IDLE;
                playing  <= 1'b0;
`endif
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_music_track_player.sv
// tb_music_track_player: scoreboard bench for music_track_player (CLKS_PER_BEAT=4, GAP_CLKS=2, 8 notes)
module tb_music_track_player;
  localparam int CPB = 4;
  localparam int GAPC = 2;
  localparam int NPT = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] select = '0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [3:0] pitch;
  logic playing;
  logic [1:0] track;
  logic [2:0] note_idx;
  logic done;
  logic [10:0] sb[$];
  int tests = 0;
  int fails = 0;

  music_track_player #(.CLKS_PER_BEAT(CPB), .GAP_CLKS(GAPC), .NOTES_PER_TRACK(NPT)) dut (
    .clk(clk), .reset(reset), .select(select), .start(start), .stop(stop),
    .pitch(pitch), .playing(playing), .track(track), .note_idx(note_idx), .done(done)
  );

  always #5 clk = ~clk;

  // sample layout: {done, playing, track, note_idx, pitch}
  function automatic logic [10:0] pk(input int d, input int pl, input int t, input int i, input int p);
    return {1'(d), 1'(pl), 2'(t), 3'(i), 4'(p)};
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got done=%b playing=%b track=%0d note=%0d pitch=%0d, want done=%b playing=%b track=%0d note=%0d pitch=%0d",
               tag, got[10], got[9], got[8:7], got[6:4], got[3:0], exp[10], exp[9], exp[8:7], exp[6:4], exp[3:0]);
    end
  endtask

  // expected cycles of iters passes over track t, ending with the done cycle
  task automatic gen(input int t, input int iters);
    for (int k = 0; k < iters; k++)
      for (int i = 0; i < NPT; i++) begin
        for (int c = 0; c < (i % 3 + 1) * CPB; c++)
          sb.push_back(pk(k > 0 && i == 0 && c == 0, 1, t, i, (3 * t + i) % 15 + 1));
        for (int c = 0; c < GAPC; c++) sb.push_back(pk(0, 1, t, i, 0));
      end
`ifdef TRACK_LOOP_EN
    sb.push_back(pk(1, 1, t, 0, (3 * t) % 15 + 1));
`else
    sb.push_back(pk(1, 0, t, 0, 0));
`endif
  endtask

  task automatic cycle(input string tag);
    logic [10:0] e;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(tag, {done, playing, track, note_idx, pitch}, e);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int c = 0; c < n && sb.size() > 0; c++) cycle(tag);
  endtask

  task automatic kick(input int t);
    select = 2'(t);
    start = 1'b1;
  endtask

  task automatic play(input string tag, input int t, input int iters);
    kick(t);
    gen(t, iters);
    run(tag, 100000);
`ifdef TRACK_LOOP_EN
    stop = 1'b1;
`endif
    sb.push_back(pk(0, 0, t, 0, 0));
    run({tag, "_idle"}, 1);
  endtask

  initial begin
    @(negedge clk);
    check("reset", {done, playing, track, note_idx, pitch}, '0);
    reset = 1'b1;
    sb.push_back(pk(0, 0, 0, 0, 0));
    run("idle", 1);
    play("trk1", 1, 1);
    play("trk0", 0, 1);
    play("trk3", 3, 1);
    kick(0);
    gen(0, 1);
    run("pre_restart", 10);
    sb.delete();
    kick(2);
    play("restart", 2, 1);
    kick(3);
    gen(3, 1);
    run("pre_stop", 5);
    sb.delete();
    stop = 1'b1;
    kick(1);
    sb.push_back(pk(0, 0, 3, 0, 0));
    run("stop_start", 1);
    kick(1);
    gen(1, 1);
    run("pre_areset", 3);
    sb.delete();
    #2 reset = 1'b0;
    #1 check("async_reset", {done, playing, track, note_idx, pitch}, '0);
    @(negedge clk);
    check("reset_hold", {done, playing, track, note_idx, pitch}, '0);
    reset = 1'b1;
`ifdef TRACK_LOOP_EN
    play("loop0", 0, 2);
`else
    play("again0", 0, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
